// File: rtl/sfifo_prefetch_ctrl.sv
// Single-clock FIFO controller for an external simple dual-port RAM. A small
// register prefetch buffer hides the RAM read latency and presents a show-ahead pop port.
module sfifo_prefetch_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTHBIT    = 10,
    parameter int RAM_OUT_REG = 1,
    parameter int AFULL_TH    = 1016
) (
    input  logic                  clks,
    input  logic                  rst_n,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  full,
    output logic                  afull,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  empty,
    output logic [DEPTHBIT:0]     usedw,
    output logic                  ovf,
    output logic                  udf,
    output logic                  ram_wren,
    output logic [DEPTHBIT-1:0]   ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [DEPTHBIT-1:0]   ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam int              RD_LAT    = 1 + RAM_OUT_REG;
    localparam logic [DEPTHBIT:0] CAPACITY  = {1'b1, {DEPTHBIT{1'b0}}};
    localparam logic [DEPTHBIT:0] AFULL_LVL = (DEPTHBIT + 1)'(AFULL_TH);
    localparam logic [DEPTHBIT:0] PTR_ONE   = (DEPTHBIT + 1)'(1);

    logic [DEPTHBIT:0]     wptr_q, wptr_d;
    logic [DEPTHBIT:0]     rptr_q, rptr_d;
    logic [DEPTHBIT:0]     usedw_q, usedw_d;
    logic [RD_LAT-1:0]     tok_q, tok_d;
    logic [DATA_WIDTH-1:0] buf_q [4];
    logic [DATA_WIDTH-1:0] buf_d [4];
    logic [1:0]            head_q, head_d;
    logic [1:0]            tail_q, tail_d;
    logic [2:0]            buf_cnt_q, buf_cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic                  push, pop, issue, capture;
    logic [2:0]            inflight;
    logic [DEPTHBIT:0]     ram_cnt;

    always_comb begin
        full      = (usedw_q == CAPACITY);
        afull     = (usedw_q >= AFULL_LVL);
        empty     = (buf_cnt_q == 3'd0);
        usedw     = usedw_q;
        ovf       = ovf_q;
        udf       = udf_q;
        rdata     = buf_q[head_q];

        push      = wen & ~full;
        pop       = ren & ~empty;
        ram_wren  = push;
        ram_wdata = wdata;
        ram_waddr = wptr_q[DEPTHBIT-1:0];
        ram_raddr = rptr_q[DEPTHBIT-1:0];
        ram_cnt   = wptr_q - rptr_q;

        inflight = 3'd0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + {2'b00, tok_q[i]};
        end

        // Reads are only issued when the buffer is guaranteed a free slot on return.
        issue   = (ram_cnt != '0) && ((inflight + buf_cnt_q) < 3'd4);
        capture = tok_q[RD_LAT-1];
    end

    always_comb begin
        wptr_d = push  ? wptr_q + PTR_ONE : wptr_q;
        rptr_d = issue ? rptr_q + PTR_ONE : rptr_q;

        tok_d    = '0;
        tok_d[0] = issue;
        for (int i = 1; i < RD_LAT; i++) begin
            tok_d[i] = tok_q[i-1];
        end

        buf_d = buf_q;
        if (capture) begin
            buf_d[tail_q] = ram_q;
        end
        tail_d = capture ? tail_q + 2'd1 : tail_q;
        head_d = pop     ? head_q + 2'd1 : head_q;

        buf_cnt_d = buf_cnt_q;
        if (capture && !pop) begin
            buf_cnt_d = buf_cnt_q + 3'd1;
        end else if (!capture && pop) begin
            buf_cnt_d = buf_cnt_q - 3'd1;
        end

        usedw_d = usedw_q;
        if (push && !pop) begin
            usedw_d = usedw_q + PTR_ONE;
        end else if (!push && pop) begin
            usedw_d = usedw_q - PTR_ONE;
        end

        ovf_d = wen & full;
        udf_d = ren & empty;
    end

    always_ff @(posedge clks or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            usedw_q   <= '0;
            tok_q     <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            buf_cnt_q <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            usedw_q   <= usedw_d;
            tok_q     <= tok_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            buf_cnt_q <= buf_cnt_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            for (int i = 0; i < 4; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

endmodule
